// File: rtl/dbscan_feeder_if.sv
// Sample-stream handshake between the sample source and dbscan_feeder.
//
// Handshake rule: a sample (in_data, in_last) is transferred on a rising
// clock edge where in_valid && in_ready are both high. The source must hold
// in_data/in_last/in_valid stable while in_valid is high and in_ready is low.
// in_ready depends only on the feeder's state, never on in_valid.
//
// Signals:
//   in_data  : raw W-bit sample (source -> feeder)
//   in_valid : sample offered (source -> feeder)
//   in_last  : sample closes the batch, qualified by in_valid (source -> feeder)
//   in_ready : feeder accepts a sample this cycle (feeder -> source)
interface dbscan_feeder_if #(
  parameter int W = 10
) ();
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/dbscan_feeder.sv
// dbscan_feeder: collects a batch of raw samples, insertion-sorts them into a
// register chain as they arrive, replays the sorted batch to the DBSCAN
// argument stage with its start/final sequence, then captures the cluster
// count the stage returns.
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   s_in         : sample stream (slave side of dbscan_feeder_if)
//   val_out      : sorted value to the argument stage in0
//   start_o      : argument stage start
//   final_o      : argument stage final
//   clust_in     : cluster count from the argument stage out0
//   count_out    : captured cluster count, held until the next capture
//   count_valid  : one-cycle strobe in the first LOAD cycle after a capture
//   busy         : high in every state except LOAD
//   o_dbg_state  : current FSM state, for checkers
module dbscan_feeder #(
  parameter int W = 10,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  dbscan_feeder_if.slave s_in,
  output logic [W-1:0] val_out,
  output logic         start_o,
  output logic         final_o,
  input  logic [W-1:0] clust_in,
  output logic [W-1:0] count_out,
  output logic         count_valid,
  output logic         busy,
  output logic [2:0]   o_dbg_state
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_PRIME  = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_FIN    = 3'd4,
    S_CAP    = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_s   [N];
  logic [W-1:0]  w_ins [N];
  logic [N-1:0]  w_big;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_last_idx;
  logic          w_accept;
  logic          w_close;

  assign w_accept   = (r_state == S_LOAD) && s_in.in_valid;
  // The N-th accepted sample closes the batch even without in_last.
  assign w_close    = w_accept && (s_in.in_last || (r_cnt == CW'(N - 1)));
  assign w_last_idx = IW'(r_cnt - 1'b1);

  // Parallel insertion. Empty slots count as "bigger" than the new sample;
  // since the chain is sorted, w_big is a run of 0s followed by 1s. The new
  // sample lands in the first big slot and big entries shift up by one.
  // Using strict > keeps equal values ahead of the newcomer (stable sort).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_big[i] = (i >= int'(r_cnt)) || (r_s[i] > s_in.in_data);
    end
    w_ins[0] = w_big[0] ? s_in.in_data : r_s[0];
    for (int i = 1; i < N; i++) begin
      if (!w_big[i])          w_ins[i] = r_s[i];
      else if (!w_big[i - 1]) w_ins[i] = s_in.in_data;
      else                    w_ins[i] = r_s[i - 1];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:   if (w_close) w_next = S_PRIME;
      S_PRIME:  w_next = (r_cnt == CW'(1)) ? S_FLUSH : S_STREAM;
      S_STREAM: if (r_idx == w_last_idx) w_next = S_FLUSH;
      S_FLUSH:  w_next = S_FIN;
      S_FIN:    w_next = S_CAP;
      S_CAP:    w_next = S_LOAD;
      default:  w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_idx       <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      for (int i = 0; i < N; i++) r_s[i] <= '0;
    end else begin
      r_state     <= w_next;
      count_valid <= (r_state == S_CAP);
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_s   <= w_ins;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRIME:  r_idx <= IW'(1);
        S_STREAM: r_idx <= r_idx + 1'b1;
        S_CAP: begin
          count_out <= clust_in;
          r_cnt     <= '0;
          r_idx     <= '0;
          for (int i = 0; i < N; i++) r_s[i] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches an output.
  always_comb begin
    val_out = '0;
    start_o = 1'b0;
    final_o = 1'b0;
    case (r_state)
      S_PRIME:  val_out = r_s[0];
      S_STREAM: begin
        val_out = r_s[r_idx];
        start_o = 1'b1;
      end
      S_FLUSH: begin
        val_out = r_s[w_last_idx];
        start_o = 1'b1;
      end
      S_FIN:    final_o = 1'b1;
      default: ;
    endcase
  end

  assign s_in.in_ready = (r_state == S_LOAD);
  assign busy          = (r_state != S_LOAD);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dbscan_feeder.sv
// Testbench for dbscan_feeder: table-driven batches from the test plan,
// randomized batches checked against a sorted-queue reference, and
// hand-written reset-mid-stream and back-to-back sequences.
module tb_dbscan_feeder;
  localparam int W = 10;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] val_out;
  logic         start_o;
  logic         final_o;
  logic [W-1:0] clust_in;
  logic [W-1:0] count_out;
  logic         count_valid;
  logic         busy;
  logic [2:0]   dbg_state;

  dbscan_feeder_if #(.W(W)) sif ();

  dbscan_feeder #(.W(W), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_in        (sif.slave),
    .val_out     (val_out),
    .start_o     (start_o),
    .final_o     (final_o),
    .clust_in    (clust_in),
    .count_out   (count_out),
    .count_valid (count_valid),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] batch_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_count;

  typedef struct {
    int           n;
    logic [W-1:0] v   [N];
    logic [W-1:0] srt [N];
    bit           use_last;
    logic [W-1:0] clust;
    bit           hold;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cycle(input string nm, input logic [W-1:0] v, input bit st,
                           input bit fi, input bit bz, input bit cv);
    chk({nm, " val_out"},     32'(val_out),     32'(v));
    chk({nm, " start_o"},     32'(start_o),     32'(st));
    chk({nm, " final_o"},     32'(final_o),     32'(fi));
    chk({nm, " busy"},        32'(busy),        32'(bz));
    chk({nm, " in_ready"},    32'(sif.in_ready), 32'(!bz));
    chk({nm, " count_valid"}, 32'(count_valid), 32'(cv));
    chk({nm, " count_out"},   32'(count_out),   32'(exp_count));
  endtask

  // Reference: stable ascending order, each sample placed after all
  // earlier samples that are not greater than it.
  task automatic model_sort();
    exp_q = {};
    foreach (batch_q[k]) begin
      int pos = exp_q.size();
      for (int j = 0; j < exp_q.size(); j++) begin
        if (exp_q[j] > batch_q[k]) begin
          pos = j;
          break;
        end
      end
      exp_q.insert(pos, batch_q[k]);
    end
  endtask

  // Drives batch_q; returns right after the closing accept edge.
  task automatic feed(input bit use_last, input bit nowait);
    int n = batch_q.size();
    for (int k = 0; k < n; k++) begin
      if (!(nowait && k == 0)) @(negedge clk);
      chk("load in_ready", 32'(sif.in_ready), 32'd1);
      chk("load busy", 32'(busy), 32'd0);
      sif.in_valid = 1'b1;
      sif.in_data  = batch_q[k];
      sif.in_last  = use_last && (k == n - 1);
    end
    @(posedge clk);
  endtask

  // Full batch: feed, then check every cycle from PRIME to count_valid
  // against exp_q. hold keeps in_valid high while busy; keep leaves the bench
  // parked at the count_valid negedge for a back-to-back follow-on batch.
  task automatic run_batch(input bit use_last, input logic [W-1:0] clust,
                           input bit hold, input bit nowait, input bit keep);
    int n = exp_q.size();
    feed(use_last, nowait);
    @(negedge clk);
    chk_cycle("prime", exp_q[0], 1'b0, 1'b0, 1'b1, 1'b0);
    sif.in_valid = hold;
    sif.in_last  = 1'b0;
    clust_in     = clust;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      chk_cycle("stream", exp_q[k], 1'b1, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    chk_cycle("flush", exp_q[n-1], 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_cycle("fin", '0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_cycle("cap", '0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_count = clust;
    @(negedge clk);
    chk_cycle("cvalid", '0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (!keep) sif.in_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    sif.in_last  = 1'b0;
    clust_in     = '0;
    exp_count    = '0;

    tbl[0].n = 4; tbl[0].v = '{5,3,9,4,0,0,0,0}; tbl[0].srt = '{3,4,5,9,0,0,0,0};
    tbl[0].use_last = 1; tbl[0].clust = 2; tbl[0].hold = 0;
    tbl[1].n = 1; tbl[1].v = '{7,0,0,0,0,0,0,0}; tbl[1].srt = '{7,0,0,0,0,0,0,0};
    tbl[1].use_last = 1; tbl[1].clust = 1; tbl[1].hold = 0;
    tbl[2].n = 8; tbl[2].v = '{8,7,6,5,4,3,2,1}; tbl[2].srt = '{1,2,3,4,5,6,7,8};
    tbl[2].use_last = 0; tbl[2].clust = 3; tbl[2].hold = 1;
    tbl[3].n = 4; tbl[3].v = '{4,4,2,4,0,0,0,0}; tbl[3].srt = '{2,4,4,4,0,0,0,0};
    tbl[3].use_last = 1; tbl[3].clust = 1023; tbl[3].hold = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cycle("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Table-driven test-plan batches.
    for (int t = 0; t < 4; t++) begin
      batch_q = {};
      exp_q   = {};
      for (int k = 0; k < tbl[t].n; k++) begin
        batch_q.push_back(tbl[t].v[k]);
        exp_q.push_back(tbl[t].srt[k]);
      end
      run_batch(tbl[t].use_last, tbl[t].clust, tbl[t].hold, 1'b0, 1'b0);
    end

    // Reset during STREAM of a 5-sample batch.
    batch_q = '{10, 20, 5, 15, 1};
    feed(1'b1, 1'b0);
    @(negedge clk);
    sif.in_valid = 1'b0;
    @(negedge clk);
    chk("midreset pre start_o", 32'(start_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    exp_count = '0;
    chk_cycle("midreset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    batch_q = '{1, 2};
    exp_q   = '{1, 2};
    run_batch(1'b1, 10'd6, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second batch offered in the count_valid cycle.
    batch_q = '{30, 10, 20};
    model_sort();
    run_batch(1'b1, 10'd11, 1'b0, 1'b0, 1'b1);
    batch_q = '{9, 9, 0};
    model_sort();
    run_batch(1'b1, 10'd12, 1'b1, 1'b1, 1'b0);

    // Randomized batches against the sorted-queue reference.
    for (int r = 0; r < 25; r++) begin
      int  n  = $urandom_range(1, N);
      bit  ul = (n < N) ? 1'b1 : 1'($urandom_range(0, 1));
      int  mx = (r % 2 == 0) ? 15 : 1023;
      batch_q = {};
      for (int k = 0; k < n; k++) batch_q.push_back(W'($urandom_range(0, mx)));
      model_sort();
      run_batch(ul, W'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                1'b0, 1'($urandom_range(0, 1)));
      sif.in_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
